// File: rtl/wb_if.sv
// Pipelined Wishbone bus bundle shared by the bench masters and the simulation controller slave.
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    output cyc, stb, we, sel, adr, dat_m,
    input  dat_s, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_m,
    output dat_s, ack, err, stall
  );
endinterface

// File: rtl/wb_sim_ctrl.sv
// Simulation controller slave: exit code / watchdog termination, console FIFO, cycle counter, scratch.
// Latency: one ack or err per accepted request, exactly one cycle after acceptance.
// Backpressure: stall only for a CONSOLE write while the FIFO is full; console side is valid/ready.
module wb_sim_ctrl #(
  parameter int          FIFO_DEPTH      = 16,
  parameter logic [31:0] TIMEOUT_DEFAULT = 32'd350,
  parameter int          CNT_WIDTH       = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  wb_if.slave        wb,
  output logic       con_valid,
  output logic [7:0] con_data,
  input  logic       con_ready,
  output logic       done,
  output logic       pass,
  output logic       timed_out,
  output logic [7:0] exit_code
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int HW = CNT_WIDTH - 32;

  localparam logic [2:0] REG_EXIT    = 3'd0;
  localparam logic [2:0] REG_CONSOLE = 3'd1;
  localparam logic [2:0] REG_CYC_LO  = 3'd2;
  localparam logic [2:0] REG_CYC_HI  = 3'd3;
  localparam logic [2:0] REG_TIMEOUT = 3'd4;
  localparam logic [2:0] REG_SCRATCH = 3'd5;

  logic [7:0]           fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [LW-1:0]        level;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [HW-1:0]        cnt_hi;
  logic [31:0]          timeout;
  logic [31:0]          scratch;
  logic [31:0]          rd_dat;
  logic [2:0]           reg_idx;
  logic                 req_vld;
  logic                 fifo_full;
  logic                 accept;
  logic                 err_hit;
  logic                 wr_en;
  logic                 rd_en;
  logic                 exit_wr;
  logic                 push;
  logic                 pop;
  logic                 wdog_fire;
  logic                 unused_adr;

  assign unused_adr = ^{wb.adr[31:5], wb.adr[1:0]};
  assign reg_idx    = wb.adr[4:2];
  assign req_vld    = wb.cyc & wb.stb;
  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  // Full is registered, so a pop in the same cycle cannot release stall.
  assign wb.stall   = req_vld & wb.we & (reg_idx == REG_CONSOLE) & fifo_full;
  assign accept     = req_vld & ~wb.stall;
  assign err_hit    = reg_idx[2] & reg_idx[1];
  assign wr_en      = accept & wb.we & ~err_hit;
  assign rd_en      = accept & ~wb.we & ~err_hit;
  assign exit_wr    = wr_en & (reg_idx == REG_EXIT) & wb.sel[0] & ~done;
  assign push       = wr_en & (reg_idx == REG_CONSOLE) & wb.sel[0];
  assign pop        = con_valid & con_ready;
  assign cnt_inc    = cnt + CNT_WIDTH'(1);
  assign wdog_fire  = (timeout != 32'd0) & ~done & (cnt_inc == CNT_WIDTH'(timeout));
  assign con_valid  = (level != '0);
  assign con_data   = con_valid ? fifo_mem[rd_ptr] : 8'h00;

  always_comb begin
    rd_dat = '0;
    case (reg_idx)
      REG_EXIT:    rd_dat = {done, 23'b0, exit_code};
      REG_CONSOLE: rd_dat = 32'(level);
      REG_CYC_LO:  rd_dat = cnt[31:0];
      REG_CYC_HI:  rd_dat = 32'(cnt_hi);
      REG_TIMEOUT: rd_dat = timeout;
      REG_SCRATCH: rd_dat = scratch;
      default:     rd_dat = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) fifo_mem[wr_ptr] <= wb.dat_m[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb.ack    <= 1'b0;
      wb.err    <= 1'b0;
      wb.dat_s  <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timed_out <= 1'b0;
      exit_code <= 8'h00;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      cnt       <= '0;
      cnt_hi    <= '0;
      timeout   <= TIMEOUT_DEFAULT;
      scratch   <= '0;
    end else begin
      wb.ack   <= accept & ~err_hit;
      wb.err   <= accept & err_hit;
      wb.dat_s <= rd_en ? rd_dat : 32'd0;

      if (!done) cnt <= cnt_inc;

      // A software exit on the expiry edge takes priority over the watchdog.
      if (exit_wr) begin
        done      <= 1'b1;
        exit_code <= wb.dat_m[7:0];
        pass      <= (wb.dat_m[7:0] == 8'h00);
      end else if (wdog_fire) begin
        done      <= 1'b1;
        timed_out <= 1'b1;
        pass      <= 1'b0;
        exit_code <= 8'hFF;
      end

      // Upper counter half is captured with the low read for a tear-free 64-bit pair.
      if (rd_en && reg_idx == REG_CYC_LO) cnt_hi <= cnt[CNT_WIDTH-1:32];

      for (int b = 0; b < 4; b++) begin
        if (wr_en && reg_idx == REG_TIMEOUT && wb.sel[b]) timeout[8*b +: 8] <= wb.dat_m[8*b +: 8];
        if (wr_en && reg_idx == REG_SCRATCH && wb.sel[b]) scratch[8*b +: 8] <= wb.dat_m[8*b +: 8];
      end

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (!push && pop) level <= level - LW'(1);
    end
  end
endmodule

// File: tb/tb_wb_sim_ctrl.sv
// Directed + randomized bench for wb_sim_ctrl with a queue/arithmetic reference model.
module tb_wb_sim_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       con_ready = 1'b0;
  logic       con_valid;
  logic [7:0] con_data;
  logic       done;
  logic       pass;
  logic       timed_out;
  logic [7:0] exit_code;

  int n_chk  = 0;
  int n_pass = 0;
  int edge_n = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  logic        a17, e17;
  logic [31:0] r17;
  int          acc17, pop_neg;

  always #5 clk = ~clk;

  wb_if wb();

  wb_sim_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wb(wb),
    .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready),
    .done(done), .pass(pass), .timed_out(timed_out), .exit_code(exit_code)
  );

  // Edges since reset release; equals the expected cycle counter while the run is live.
  always @(posedge clk) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  always @(negedge clk) begin
    if (rst_n && con_valid && con_ready) rx_q.push_back(con_data);
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] wdat, output logic [31:0] rdat,
                         output logic ack_o, output logic err_o, output int acc_neg);
    int guard;
    @(posedge clk); #1;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we; wb.adr = adr; wb.sel = sel; wb.dat_m = wdat;
    guard = 0;
    @(negedge clk);
    while (wb.stall && guard < 300) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 300) chk("stall_bound", 64'(guard), 0);
    acc_neg = edge_n;
    @(posedge clk); #1;
    wb.stb = 1'b0;
    @(negedge clk);
    rdat = wb.dat_s; ack_o = wb.ack; err_o = wb.err;
    @(posedge clk); #1;
    wb.cyc = 1'b0; wb.we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] d,
                    output logic ack_o, output logic err_o);
    logic [31:0] rdat;
    int an;
    wb_xfer(1'b1, adr, sel, d, rdat, ack_o, err_o, an);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] d, output logic ack_o, output logic err_o);
    int an;
    wb_xfer(1'b0, adr, 4'hF, 32'd0, d, ack_o, err_o, an);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rdat, v, m_scr, exp_lo;
    logic        a, e, a1, a2;
    logic [31:0] d1, d2;
    logic [3:0]  s;
    int          an, guard, n, nto;

    wb.cyc = 0; wb.stb = 0; wb.we = 0; wb.sel = 0; wb.adr = 0; wb.dat_m = 0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", wb.ack, 0);
    chk("rst_err", wb.err, 0);
    chk("rst_stall", wb.stall, 0);
    chk("rst_dat_s", wb.dat_s, 0);
    chk("rst_con_valid", con_valid, 0);
    chk("rst_con_data", con_data, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timed_out", timed_out, 0);
    chk("rst_exit_code", exit_code, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle run ends by the default watchdog on edge 350
    guard = 0;
    @(negedge clk);
    while (!done && guard < 500) begin guard++; @(negedge clk); end
    chk("wdog_default_edge", 64'(edge_n), 350);
    chk("wdog_timed_out", timed_out, 1);
    chk("wdog_pass", pass, 0);
    chk("wdog_exit_code", exit_code, 8'hFF);
    rd(32'h08, rdat, a, e);
    chk("cyc_lo_frozen", rdat, 350);
    repeat (10) @(posedge clk);
    rd(32'h08, rdat, a, e);
    chk("cyc_lo_still_frozen", rdat, 350);
    rd(32'h0C, rdat, a, e);
    chk("cyc_hi_frozen", rdat, 0);
    rd(32'h00, rdat, a, e);
    chk("exit_read_wdog", rdat, 32'h8000_00FF);

    // Software exit 0 accepted on edge 20
    do_reset();
    rd(32'h10, rdat, a, e);
    chk("timeout_reset_value", rdat, 350);
    guard = 0;
    @(negedge clk);
    while (edge_n < 18 && guard < 100) begin guard++; @(negedge clk); end
    chk("exit0_pre_done", done, 0);
    wb_xfer(1'b1, 32'h00, 4'h1, 32'h0, rdat, a, e, an);
    chk("exit0_accept_edge", 64'(an + 1), 20);
    chk("exit0_ack", a, 1);
    chk("exit0_done", done, 1);
    chk("exit0_pass", pass, 1);
    chk("exit0_code", exit_code, 0);
    chk("exit0_timed_out", timed_out, 0);
    v = 32'($urandom_range(1, 255));
    wr(32'h00, 4'h1, v, a, e);
    chk("exit2_ack", a, 1);
    chk("exit2_code_sticky", exit_code, 0);
    chk("exit2_pass_sticky", pass, 1);
    rd(32'h00, rdat, a, e);
    chk("exit_read_pass", rdat, 32'h8000_0000);

    // Watchdog disabled; exit 0x2A at edge 1000
    do_reset();
    wr(32'h10, 4'hF, 32'h0, a, e);
    guard = 0;
    @(negedge clk);
    while (edge_n < 998 && guard < 2000) begin guard++; @(negedge clk); end
    chk("nowdog_done_before", done, 0);
    wb_xfer(1'b1, 32'h00, 4'h1, 32'h2A, rdat, a, e, an);
    chk("exit2a_done", done, 1);
    chk("exit2a_pass", pass, 0);
    chk("exit2a_code", exit_code, 8'h2A);
    chk("exit2a_timed_out", timed_out, 0);
    rd(32'h08, rdat, a, e);
    chk("exit2a_cycles", rdat, 32'(an + 1));

    // Console FIFO fill, stall, in-order drain
    do_reset();
    con_ready = 1'b0;
    rx_q.delete(); exp_q.delete();
    n = 0;
    for (int i = 0; i < 16; i++) begin
      wr(32'h04, 4'h1, 32'h41 + 32'(i), a, e);
      if (a) n++;
      exp_q.push_back(8'(8'h41 + i));
    end
    chk("con_fill_acks", 64'(n), 16);
    rd(32'h04, rdat, a, e);
    chk("con_level_full", rdat, 16);
    chk("con_head", con_data, 8'h41);
    fork
      begin
        wb_xfer(1'b1, 32'h04, 4'h1, 32'h51, r17, a17, e17, acc17);
      end
      begin
        repeat (6) @(negedge clk);
        chk("con_stall_full", wb.stall, 1);
        @(posedge clk); #1;
        con_ready = 1'b1;
        @(negedge clk);
        pop_neg = edge_n;
        chk("con_stall_same_pop", wb.stall, 1);
      end
    join
    exp_q.push_back(8'h51);
    chk("con_17_ack", a17, 1);
    chk("con_stall_release_edge", 64'(acc17), 64'(pop_neg + 1));
    guard = 0;
    while (rx_q.size() < 17 && guard < 200) begin guard++; @(negedge clk); end
    chk("con_rx_count", 64'(rx_q.size()), 17);
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) chk("con_byte", rx_q[i], exp_q[i]);
    rd(32'h04, rdat, a, e);
    chk("con_level_empty", rdat, 0);

    // Random console bytes with random byte enables
    rx_q.delete(); exp_q.delete();
    nto = $urandom_range(3, 8);
    for (int i = 0; i < nto; i++) begin
      v = 32'($urandom_range(0, 255));
      s = 4'($urandom);
      wr(32'h04, s, v, a, e);
      if (s[0]) exp_q.push_back(v[7:0]);
    end
    repeat (4) @(negedge clk);
    chk("con_rand_count", 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) chk("con_rand_byte", rx_q[i], exp_q[i]);
    con_ready = 1'b0;

    // Random watchdog period
    do_reset();
    nto = $urandom_range(60, 120);
    wr(32'h10, 4'hF, 32'(nto), a, e);
    guard = 0;
    @(negedge clk);
    while (!done && guard < 300) begin guard++; @(negedge clk); end
    chk("wdog_rand_edge", 64'(edge_n), 64'(nto));
    chk("wdog_rand_code", exit_code, 8'hFF);
    chk("wdog_rand_to", timed_out, 1);

    // Exit write lands exactly on the expiry edge
    do_reset();
    nto = $urandom_range(40, 90);
    wr(32'h10, 4'hF, 32'(nto), a, e);
    guard = 0;
    @(negedge clk);
    while (edge_n < nto - 2 && guard < 300) begin guard++; @(negedge clk); end
    wb_xfer(1'b1, 32'h00, 4'h1, 32'h3, rdat, a, e, an);
    chk("collide_edge", 64'(an + 1), 64'(nto));
    chk("collide_code", exit_code, 8'h03);
    chk("collide_to", timed_out, 0);
    chk("collide_done", done, 1);

    // Error window, scratch byte enables
    do_reset();
    rd(32'h18, rdat, a, e);
    chk("err18_err", e, 1);
    chk("err18_ack", a, 0);
    chk("err18_dat", rdat, 0);
    wr(32'h1C, 4'hF, 32'h1234, a, e);
    chk("err1c_err", e, 1);
    wr(32'h14, 4'b0011, 32'hDEAD_BEEF, a, e);
    rd(32'h14, rdat, a, e);
    chk("scratch_be", rdat, 32'h0000_BEEF);
    m_scr = 32'h0000_BEEF;
    for (int k = 0; k < 3; k++) begin
      v = $urandom;
      s = 4'($urandom);
      wr(32'h14, s, v, a, e);
      for (int b = 0; b < 4; b++) if (s[b]) m_scr[8*b +: 8] = v[8*b +: 8];
      rd(32'h14, rdat, a, e);
      chk("scratch_rand", rdat, m_scr);
    end

    // Back-to-back pipelined CYCLE_LO / CYCLE_HI
    @(posedge clk); #1;
    wb.cyc = 1; wb.stb = 1; wb.we = 0; wb.sel = 4'hF; wb.adr = 32'h08;
    @(negedge clk);
    exp_lo = 32'(edge_n);
    @(posedge clk); #1;
    wb.adr = 32'h0C;
    @(negedge clk);
    a1 = wb.ack; d1 = wb.dat_s;
    @(posedge clk); #1;
    wb.stb = 0;
    @(negedge clk);
    a2 = wb.ack; d2 = wb.dat_s;
    @(posedge clk); #1;
    wb.cyc = 0;
    chk("pipe_ack_lo", a1, 1);
    chk("pipe_ack_hi", a2, 1);
    chk("pipe_lo", d1, exp_lo);
    chk("pipe_hi", d2, 0);

    // Reset in the middle of a burst
    do_reset();
    wr(32'h04, 4'h1, 32'h77, a, e);
    @(posedge clk); #1;
    wb.cyc = 1; wb.stb = 1; wb.we = 1; wb.sel = 4'h1; wb.adr = 32'h00; wb.dat_m = 32'h7;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("burst_ack_pending", wb.ack, 1);
    chk("burst_done_pre", done, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("burst_rst_ack", wb.ack, 0);
    chk("burst_rst_done", done, 0);
    chk("burst_rst_code", exit_code, 0);
    chk("burst_rst_con_valid", con_valid, 0);
    chk("burst_rst_pass", pass, 0);
    wb.cyc = 0; wb.stb = 0; wb.we = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_sim_ctrl.md
Name: wb_sim_ctrl

Overview:
Wishbone (pipelined) slave simulation controller for the core/RAM benches. It replaces fixed-length runs with program-driven termination: software writes an exit code, or a programmable watchdog ends the run. It also provides a console byte stream through a FIFO, a 64-bit cycle counter and a scratch register. It hangs off the shared-bus interconnect as an extra slave; decode is local on adr[4:2].

Parameters:
FIFO_DEPTH, 16, console FIFO entries; power of two, >= 2
TIMEOUT_DEFAULT, 350, reset value of TIMEOUT register in cycles; 0 = watchdog disabled
CNT_WIDTH, 64, cycle counter width; 33..64

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
wb  interface  wb_if.slave  Wishbone slave; uses cyc, stb, we, sel[3:0], adr[31:0], dat_m[31:0], dat_s[31:0], ack, err, stall
con_valid  output  1  console byte available
con_data  output  8  console byte (FIFO head)
con_ready  input  1  consumer takes byte when con_valid & con_ready
done  output  1  run finished (sticky)
pass  output  1  done with exit code 0
timed_out  output  1  done caused by watchdog
exit_code  output  8  final exit code

Behaviour:
- Reset (rst_n low at clk edge): ack=0, err=0, stall=0, dat_s=0, con_valid=0, con_data=0, done=0, pass=0, timed_out=0, exit_code=0, FIFO empty, counter=0, TIMEOUT=TIMEOUT_DEFAULT, SCRATCH=0. Reset mid-transaction drops any pending ack; the master must restart.
- Handshake: request accepted when cyc & stb & !stall. Exactly one ack or err pulse, one cycle after acceptance. Back-to-back accepts give back-to-back acks. dat_s is valid only with ack and is 0 otherwise. No response occurs if cyc drops.
- Register map (byte offset = adr[4:0]; adr[1:0] ignored):
  0x00 EXIT RW. Write with sel[0]=1 and done=0: done<=1, exit_code<=dat_m[7:0], pass<=(dat_m[7:0]==0). Read = {done, 23'b0, exit_code}.
  0x04 CONSOLE RW. Write with sel[0]=1 pushes dat_m[7:0]. Read = FIFO level, zero-extended.
  0x08 CYCLE_LO RO. Read returns counter[31:0] and snapshots counter[CNT_WIDTH-1:32] into a HI latch.
  0x0C CYCLE_HI RO. Returns HI latch, zero-extended.
  0x10 TIMEOUT RW, byte-enable per sel.
  0x14 SCRATCH RW, byte-enable per sel.
  0x18, 0x1C: err instead of ack; no state change.
  Writes to RO registers are acked and ignored. Writes with sel[0]=0 to EXIT/CONSOLE are acked with no effect.
- Stall: asserted combinationally while FIFO is full and the current request is a CONSOLE write. A pop in the same cycle does not release stall; stall releases the cycle after level drops. Other requests are never stalled.
- FIFO: con_valid = !empty and con_data = head (registered). Simultaneous push and pop when not full or empty leaves level unchanged. Pointers wrap modulo FIFO_DEPTH. The FIFO keeps draining after done.
- Counter: increments every cycle while done=0 and freezes when done=1. It wraps at 2^CNT_WIDTH.
- Watchdog: if TIMEOUT!=0, done=0 and counter+1 == TIMEOUT on this edge, then done<=1, timed_out<=1, pass<=0, exit_code<=8'hFF.
- Simultaneous EXIT write and watchdog expiry on the same edge: EXIT write wins and timed_out stays 0.
- done, pass, timed_out and exit_code are sticky until reset. A second EXIT write is acked and ignored.
- Writing TIMEOUT at or below the current counter value: no expiry until wrap.

Test Plan:
- Reset, then idle with TIMEOUT_DEFAULT=350 -> done=1, timed_out=1, pass=0, exit_code=8'hFF at the 350th edge after reset release; counter read = 350 and stays frozen.
- Write EXIT=0 at cycle 20 -> ack next cycle, done=1, pass=1, exit_code=0. Then write EXIT=5 -> acked; exit_code stays 0 and pass stays 1.
- Write TIMEOUT=0, then EXIT=8'h2A at cycle 1000 -> no timeout; done=1, pass=0, exit_code=8'h2A, timed_out=0.
- Hold con_ready=0 and write 17 CONSOLE bytes 0x41.. (FIFO_DEPTH=16) -> 16 acks; the 17th is stalled and CONSOLE read would show 16. Raise con_ready -> bytes emerge in order 0x41..0x50; stall drops and the 17th byte (0x51) is accepted and emitted last.
- Set TIMEOUT=N, then write EXIT=3 exactly on the expiry edge -> exit_code=3, timed_out=0.
- Read 0x18 -> err pulse, no ack. Write SCRATCH=0xDEADBEEF with sel=4'b0011, then read -> 0x0000BEEF. Back-to-back pipelined reads of CYCLE_LO and CYCLE_HI -> consistent 64-bit value. Assert rst_n low mid-burst -> all outputs at reset values next edge.
